// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Iterative AES-128 key-schedule controller. A start pulse captures the
// 128-bit cipher key as w[0..3]; then one word w[4..43] is generated per
// cycle into an internal 44x32 store. Round keys 0..10 are served over a
// request/grant read port. A round can be read as soon as its last word
// has been registered, so the cipher may overlap with the expansion.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse: load cipher_key and begin expansion
//   cipher_key  [0:127] big-endian key, w[0] = bits [0:31]
//   busy        expansion in progress
//   key_ready   all round keys valid (until next accepted start or rst)
//   rk_req      round-key read request (held until granted)
//   rk_idx      requested round 0..10
//   rk_gnt      combinational grant for this cycle's request
//   rk_valid    registered, one cycle after a grant
//   rk_data     [0:127] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_err      registered, pulses with rk_valid for rk_idx > 10
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] cipher_key,
    output logic         busy,
    output logic         key_ready,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_gnt,
    output logic         rk_valid,
    output logic [0:127] rk_data,
    output logic         rk_err
);

    localparam int NUM_WORDS = 4 * (NUM_ROUNDS + 1);
    localparam int LAST_WORD = NUM_WORDS - 1;

    // FIPS-197 forward S-box.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  wr_ptr;
    logic [7:0]  rcon;
    logic        load;
    logic [31:0] store [NUM_WORDS];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // ---------------- word generator ----------------
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] temp_word;
    logic [31:0] new_word;

    assign prev_word = store[wr_ptr - 6'd1];
    assign back_word = store[wr_ptr - 6'd4];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};
    assign sub_word  = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                        SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};
    // First word of each group of four takes the RotWord/SubWord/Rcon path.
    assign temp_word = (wr_ptr[1:0] == 2'd0) ? (sub_word ^ {rcon, 24'h0}) : prev_word;
    assign new_word  = back_word ^ temp_word;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values of the others.
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= 6'd0;
            rcon   <= 8'h01;
        end else begin
            state <= state_nxt;
            if (load) begin
                wr_ptr <= 6'd4;
                rcon   <= 8'h01;
            end else if (state == EXPAND) begin
                wr_ptr <= wr_ptr + 6'd1;
                if (wr_ptr[1:0] == 2'd0) begin
                    rcon <= xtime(rcon);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        key_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start && !rst) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                busy = 1'b1;
                // start is deliberately ignored here.
                if (wr_ptr == 6'(LAST_WORD)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                key_ready = 1'b1;
                if (start && !rst) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- key store ----------------
    // NOTE: the store has no reset; its contents are never read before the
    // load that follows any reset, so a reset would only cost logic.
    always_ff @(posedge clk) begin
        if (load) begin
            store[0] <= cipher_key[0:31];
            store[1] <= cipher_key[32:63];
            store[2] <= cipher_key[64:95];
            store[3] <= cipher_key[96:127];
        end else if (state == EXPAND) begin
            store[wr_ptr] <= new_word;
        end
    end

    // ---------------- read port ----------------
    logic       idx_bad;
    logic       idx_avail;
    logic [6:0] need_ptr;
    logic [5:0] rd_base;

    assign idx_bad   = (rk_idx > 4'(NUM_ROUNDS));
    assign need_ptr  = {1'b0, rk_idx, 2'b00} + 7'd4;
    // A round is readable only once wr_ptr has moved past its last word,
    // so a read never sees a word in the cycle it is written.
    assign idx_avail = !idx_bad &&
                       ((state == READY) || ((state == EXPAND) && ({1'b0, wr_ptr} >= need_ptr)));
    assign rk_gnt    = rk_req && (idx_avail || idx_bad);
    assign rd_base   = idx_bad ? 6'd0 : {rk_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk_data  <= '0;
        end else begin
            rk_valid <= rk_gnt;
            rk_err   <= rk_gnt && idx_bad;
            if (rk_gnt) begin
                rk_data <= idx_bad ? 128'h0 :
                           {store[rd_base], store[rd_base + 6'd1],
                            store[rd_base + 6'd2], store[rd_base + 6'd3]};
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl: known-answer vector table, hand-written
// timing/corner sequences, and randomized reads checked against a
// behavioural key-expansion model whose S-box is derived from GF(2^8).
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:127] cipher_key;
    logic         busy;
    logic         key_ready;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_gnt;
    logic         rk_valid;
    logic [0:127] rk_data;
    logic         rk_err;

    aes_key_sched_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cipher_key (cipher_key),
        .busy       (busy),
        .key_ready  (key_ready),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_gnt     (rk_gnt),
        .rk_valid   (rk_valid),
        .rk_data    (rk_data),
        .rk_err     (rk_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int tests = 0;
    int fails = 0;

    logic [0:127] key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [0:127] key0 = 128'h0;
    logic [0:127] key3 = 128'h000102030405060708090a0b0c0d0e0f;

    logic [0:127] exp_hold;          // expected held value of rk_data
    logic [7:0]   sbox_m [256];
    logic [31:0]  mw [44];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef struct {
        logic [0:127] key;
        logic [3:0]   idx;
        logic [0:127] data;
        logic         err;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [0:127] k);
        logic [31:0] t;
        for (int i = 0; i < 4; i++) mw[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = mw[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rcon_tab[i/4 - 1], 24'h0};
            end
            mw[i] = mw[i-4] ^ t;
        end
    endtask

    function automatic logic [0:127] model_round(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [0:127] k);
        cipher_key = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (key_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(name, key_ready, 1);
    endtask

    // Start an expansion and check key_ready/busy timing; optionally pulse a
    // stray start with another key at cycle 20.
    task automatic run_timed(input string name, input logic [0:127] k, input bit poke);
        do_start(k);
        check({name, " busy@0"}, busy, 1);
        check({name, " key_ready@0"}, key_ready, 0);
        for (int n = 1; n <= 40; n++) begin
            if (poke && n == 20) begin
                start = 1'b1;
                cipher_key = ~k;
            end
            tick();
            start = 1'b0;
            if (n == 39) check({name, " key_ready@39"}, key_ready, 0);
        end
        check({name, " key_ready@40"}, key_ready, 1);
        check({name, " busy@40"}, busy, 0);
    endtask

    task automatic read_round(input string name, input logic [3:0] idx,
                              input logic [0:127] exp, input logic exp_err);
        int n;
        n = 0;
        rk_req = 1'b1;
        rk_idx = idx;
        #1;
        while (rk_gnt !== 1'b1 && n < 100) begin
            tick();
            #1;
            n++;
        end
        check({name, " gnt"}, rk_gnt, 1);
        tick();
        rk_req = 1'b0;
        check({name, " valid"}, rk_valid, 1);
        check({name, " data"}, rk_data, exp);
        check({name, " err"}, rk_err, exp_err);
        exp_hold = exp;
        tick();
        check({name, " valid drop"}, rk_valid, 0);
        check({name, " hold"}, rk_data, exp_hold);
    endtask

    // ---------------- test sequence ----------------
    logic [0:127] loaded;
    logic [0:127] rkey;
    bit           req_on;
    bit           prev_gnt;
    bit           prev_bad;
    bit           exp_gnt;

    initial begin
        vecs[0] = '{key1, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
        vecs[1] = '{key1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
        vecs[2] = '{key1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        vecs[3] = '{key1, 4'd12, 128'h0,                                1'b1};
        vecs[4] = '{key0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0};
        vecs[5] = '{key3, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0};
        vecs[6] = '{key3, 4'd11, 128'h0,                                1'b1};

        rst = 1'b1;
        start = 1'b0;
        cipher_key = '0;
        rk_req = 1'b0;
        rk_idx = 4'd0;
        build_sbox();
        tick();
        tick();
        rst = 1'b0;

        // Reset state; nothing is readable before an expansion.
        check("reset busy", busy, 0);
        check("reset key_ready", key_ready, 0);
        check("reset rk_valid", rk_valid, 0);
        check("reset rk_err", rk_err, 0);
        check("reset rk_data", rk_data, 0);
        exp_hold = '0;
        rk_req = 1'b1;
        #1;
        check("idle gnt", rk_gnt, 0);

        // Early read of round 2 held from the start cycle.
        rk_idx = 4'd2;
        cipher_key = key1;
        start = 1'b1;
        #1;
        check("early gnt@start", rk_gnt, 0);
        tick();
        start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            #1;
            check("early gnt stall", rk_gnt, 0);
            tick();
        end
        #1;
        check("early gnt@8", rk_gnt, 1);
        tick();
        rk_req = 1'b0;
        check("early valid", rk_valid, 1);
        check("early data", rk_data, 128'hf2c295f27a96b9435935807a7359f67f);
        exp_hold = 128'hf2c295f27a96b9435935807a7359f67f;
        wait_ready("early ready");
        loaded = key1;

        // Known-answer table.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].key !== loaded) begin
                run_timed($sformatf("vec%0d expand", v), vecs[v].key, 1'b0);
                loaded = vecs[v].key;
            end
            read_round($sformatf("vec%0d", v), vecs[v].idx, vecs[v].data, vecs[v].err);
        end

        // Stray start mid-expansion is ignored.
        run_timed("midstart", key1, 1'b1);
        read_round("midstart r1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
        read_round("midstart r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

        // Start in READY together with a grant: read returns the old key.
        rk_req = 1'b1;
        rk_idx = 4'd10;
        cipher_key = key3;
        start = 1'b1;
        #1;
        check("overlap gnt", rk_gnt, 1);
        tick();
        start = 1'b0;
        rk_req = 1'b0;
        check("overlap valid", rk_valid, 1);
        check("overlap data", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("overlap key_ready drop", key_ready, 0);
        exp_hold = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        wait_ready("overlap ready");
        read_round("overlap new r10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0);

        // Reset at cycle 15 of an expansion aborts it.
        do_start(key1);
        for (int n = 1; n < 15; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort key_ready", key_ready, 0);
        check("abort rk_valid", rk_valid, 0);
        check("abort rk_data", rk_data, 0);
        exp_hold = '0;
        rk_req = 1'b1;
        rk_idx = 4'd0;
        #1;
        check("abort gnt", rk_gnt, 0);
        tick();
        #1;
        check("abort gnt later", rk_gnt, 0);
        rk_req = 1'b0;
        run_timed("zero key", key0, 1'b0);
        read_round("zero r10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0);

        // Restart from READY.
        run_timed("restart", key3, 1'b0);
        read_round("restart r10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b0);

        // Randomized reads overlapping expansion, against the model.
        for (int t = 0; t < 6; t++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rkey);
            rk_req = 1'b0;
            do_start(rkey);
            req_on = 1'b0;
            prev_gnt = 1'b0;
            prev_bad = 1'b0;
            for (int n = 0; n <= 50; n++) begin
                check($sformatf("rnd%0d busy@%0d", t, n), busy, (n < 40) ? 1 : 0);
                check($sformatf("rnd%0d key_ready@%0d", t, n), key_ready, (n >= 40) ? 1 : 0);
                check($sformatf("rnd%0d valid@%0d", t, n), rk_valid, prev_gnt);
                check($sformatf("rnd%0d err@%0d", t, n), rk_err, prev_gnt && prev_bad);
                check($sformatf("rnd%0d data@%0d", t, n), rk_data, exp_hold);
                if (!req_on && $urandom_range(0, 1) == 1) begin
                    req_on = 1'b1;
                    rk_idx = 4'($urandom_range(0, 12));
                end
                rk_req = req_on;
                #1;
                exp_gnt = req_on && (rk_idx > 10 || n >= 4 * int'(rk_idx));
                check($sformatf("rnd%0d gnt@%0d idx%0d", t, n, rk_idx), rk_gnt, exp_gnt);
                prev_gnt = exp_gnt;
                prev_bad = (rk_idx > 10);
                if (exp_gnt) begin
                    exp_hold = (rk_idx > 10) ? 128'h0 : model_round(int'(rk_idx));
                    req_on = 1'b0;
                end
                tick();
            end
            rk_req = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Iterative AES-128 key-schedule controller. It replaces the single-shot combinational expansion with a one-word-per-cycle sequencer. The controller captures a 128-bit cipher key and generates words w[4]..w[43] into an internal 44x32 store. It then serves round keys 0..10 to the cipher round engine over a request/grant read port. The read port may return a round key as soon as that key is complete, so the cipher can overlap with expansion.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; the store holds 4*(NUM_ROUNDS+1) words. Only 10 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; load cipher_key and begin expansion
cipher_key  in  128  [0:127], big-endian; w[0] = bits [0:31]
busy  out  1  high while expansion is in progress
key_ready  out  1  all 11 round keys valid; stays high until the next accepted start or rst
rk_req  in  1  round-key read request
rk_idx  in  4  requested round, 0..10
rk_gnt  out  1  combinational; request accepted this cycle
rk_valid  out  1  registered; rk_data valid
rk_data  out  128  [0:127] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}
rk_err  out  1  registered; pulses with rk_valid when rk_idx > 10

Behaviour:
- Reset values: busy=0, key_ready=0, rk_valid=0, rk_err=0, rk_data=0. Internally, state=IDLE, wr_ptr=0 and rcon=8'h01. Store contents are don't-care.
- rst has priority over every other input. Reset mid-expansion aborts the expansion, and a subsequent read request is not granted until a new expansion completes.
- State machine:
  - IDLE: on start, write w[0..3]=cipher_key, set wr_ptr=4, rcon=8'h01, busy=1, and go to EXPAND.
  - EXPAND: each cycle write w[i], where i=wr_ptr, using temp = w[i-1].
    - If i%4==0: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}.
    - w[i] = w[i-4] ^ temp; then wr_ptr++.
    - After each i%4==0 write, rcon = xtime(rcon): shift left, XOR 8'h1b if the msb was set. This gives 01,02,...,80,1b,36.
    - On the cycle that writes i=43, go to READY, set busy=0 and key_ready=1.
  - READY: hold the store. On start, perform the IDLE load action: key_ready=0 and busy=1 from the next cycle, and the old keys are invalid.
- Latency: if start is sampled at edge E, w[4+k] is written at edge E+1+k. key_ready rises at edge E+40. A full expansion is 41 cycles.
- start during EXPAND is ignored and does not restart.
- SubWord uses four parallel combinational 256-entry S-box lookups, one per byte. This is the standard FIPS-197 forward S-box.
- Round r is available when wr_ptr >= 4r+4, and during READY.
- rk_gnt = rk_req & (available(rk_idx) | rk_idx>10).
  - If rk_req is high and the round is unavailable, rk_gnt=0. The requester holds rk_req and rk_idx stable until granted.
- A grant at edge E produces rk_valid=1 for exactly one cycle after E, carrying the data and rk_err. Back-to-back grants give a rk_valid stream with one-cycle latency.
  - A bad index (rk_idx > 10) returns rk_data=0 and rk_err=1.
  - Without a grant, rk_valid=0, rk_err=0 and rk_data holds its last value.
- Same-cycle write and read:
  - A round becomes available only after its last word is registered, so a read never observes a word in the same cycle it is written.
  - A start accepted in READY in the same cycle as a grant: the read returns the old key, and the new load lands at the same edge.

Test Plan:
1. rst, then start with key 2b7e151628aed2a6abf7158809cf4f3c, reading rk_idx 0, 1, 10 after key_ready -> round 0 = 2b7e1516...09cf4f3c; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. key_ready rises exactly 40 edges after the start edge.
2. Early read: rk_req=1, rk_idx=2 held from the start cycle -> rk_gnt stays 0 until w[11] is registered, 8 edges after start. rk_valid then returns f2c295f27a96b9435935807a7359f67f.
3. Bad index: rk_idx=12 in READY -> rk_gnt=1, next-cycle rk_valid=1, rk_err=1, rk_data=0.
4. start pulsed mid-EXPAND at cycle 20 -> ignored; keys match scenario 1 and key_ready timing is unchanged.
5. rst asserted at cycle 15 of expansion -> busy=0 next cycle and rk_req for round 0 is not granted. A fresh start with the all-zero key yields round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
6. Restart from READY with key 000102030405060708090a0b0c0d0e0f -> key_ready drops the next cycle. Round 10 = 13111d7fe3944a17f307a78b4d2b30c5 after 40 edges.
